coef_loader: RTL and testbench
==============================

# coef_loader

Upstream configuration stage for `filter_top`. It receives the NT+1 FIR coefficients as a byte-serial stream followed by a checksum byte, assembles them in a shadow register, and atomically commits them to the parallel `B` bus that drives the filter. A failed checksum leaves the active coefficient set untouched. The filter never sees a partially loaded set.

## Interface
- `NB`, 8, coefficient width in bits (two's complement)
- `NT`, 10, filter order; NT+1 coefficients per load

- `CLK` in 1: single clock, rising edge
- `RST` in 1: synchronous, active-high reset
- `CSTART` in 1: begin (or restart) a load sequence
- `CIN` in NB: serial coefficient / checksum byte
- `CVIN` in 1: `CIN` valid this cycle
- `B` out (NT+1)*NB: committed coefficients; drives `filter_top.B`
- `BUSY` out 1: load sequence in progress
- `DONE` out 1: one-cycle pulse, new set committed
- `ERR` out 1: one-cycle pulse, checksum mismatch

## Operation
- States:
  - IDLE: waiting for `CSTART`.
  - LOAD: accepting coefficient bytes.
  - CHECK: waiting for the checksum byte.
- **IDLE**
  - `CSTART`=1 -> LOAD; byte counter = 0; running sum = 0.
  - `CVIN` without `CSTART` is ignored.
- **LOAD**
  - Each `CVIN`=1 shifts `CIN` into the shadow register, adds it to the running sum (mod 2^NB), and increments the counter.
  - After byte NT+1 is accepted -> CHECK.
- **CHECK**
  - The next `CVIN`=1 byte is compared with the running sum.
  - Match: shadow -> `B`; `DONE`=1 for one cycle.
  - Mismatch: `B` is unchanged; `ERR`=1 for one cycle.
  - Either way -> IDLE.
- **Ordering**
  - The first coefficient received lands in `B[(NT+1)*NB-1 -: NB]`.
  - The last coefficient lands in `B[NB-1:0]`.
- **Checksum**
  - Unsigned sum of the NT+1 coefficient bytes, modulo 2^NB.
  - Sign is irrelevant because the arithmetic is modulo 2^NB.
- **Restart**
  - `CSTART`=1 in LOAD or CHECK discards the shadow and restarts at LOAD with the counter and sum cleared.
  - A `CVIN` byte presented in the same cycle is dropped.
- **IDLE entry**
  - `CSTART`=1 and `CVIN`=1 in the same IDLE cycle: only the start takes effect; the byte is dropped.
- **Bubbles**
  - `CVIN`=0 cycles in LOAD or CHECK are allowed, unlimited in number.
  - No timeout.

## Timing
- **Reset values**
  - `B`=0 (all-zero filter).
  - `BUSY`=0, `DONE`=0, `ERR`=0, state IDLE.
  - Shadow, counter and sum cleared.
- **`BUSY`**
  - Rises on the edge that samples `CSTART`.
  - Falls on the edge that accepts the checksum byte.
- **Commit**
  - `B`, `DONE` and `ERR` are registered.
  - They update on the same edge that accepts the checksum byte, so they are valid in the following cycle.
  - `B` changes in exactly one cycle, never byte by byte.
- **Minimum load time:** NT+3 cycles from the `CSTART` cycle to `DONE` high (1 start + NT+1 coefficients + 1 checksum).
- **Back-to-back:** `CSTART` may be asserted in the cycle `DONE` or `ERR` is high.
- **`RST` mid-load:** the sequence is aborted and `B` returns to 0. The filter consequently runs with zero coefficients until the next successful load.
- **Downstream contract:** `B` is quasi-static. The system holds `filter_top.VIN` low during a commit cycle if glitch-free output is required; `coef_loader` does not gate `VIN`.

## Structure
- **Package `coef_pkg`**
  - `NB`, `NT` defaults.
  - State enum (`S_IDLE`, `S_LOAD`, `S_CHECK`).
  - Counter width constant `$clog2(NT+2)`.
- **Sub-module `coef_shift_reg`**
  - (NT+1)×NB shadow shift register with `shift_en` and `clr`.
  - Its parallel output feeds the commit register.
- **Top `coef_loader`:** FSM, counter, checksum accumulator, output `B` register, pulse generation.

## Test plan
- **Nominal load**
  - Stimulus: reset, `CSTART`, then bytes FF FE FC 08 23 32 23 08 FC FE FF, checksum 7A.
  - Required: `DONE` pulses once; `B[87:80]`=FF, `B[55:48]`=23, `B[47:40]`=32, `B[7:0]`=FF.
- **Bad checksum**
  - Stimulus: same bytes, checksum 7B.
  - Required: `ERR` pulses once, `DONE` stays 0, `B` keeps its previous value bit for bit.
- **Bubbles**
  - Stimulus: nominal sequence with random `CVIN`=0 gaps of 0–5 cycles.
  - Required: identical `B` to the nominal load; `BUSY` high throughout.
- **Restart**
  - Stimulus: `CSTART`, 5 bytes, `CSTART`+`CVIN` together, then the full nominal sequence.
  - Required: `B` equals the nominal set and exactly one `DONE`.
- **Reset mid-load**
  - Stimulus: commit the nominal set, start a second load, assert `RST` after 6 bytes.
  - Required: `B`=0, `BUSY`=0, no `DONE`/`ERR`; a subsequent nominal load succeeds.
- **Idle noise**
  - Stimulus: `CVIN` pulses with arbitrary `CIN` while IDLE.
  - Required: no state change, `B` unchanged, `BUSY`=0.

Source files
------------

// File: rtl/coef_pkg.sv
// Shared constants and FSM state type for the FIR coefficient loader.
package coef_pkg;
  localparam int NB = 8;
  localparam int NT = 10;
  localparam int CW = $clog2(NT + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CHECK = 2'd2
  } coef_state_e;
endpackage

// File: rtl/coef_shift_reg.sv
// Shadow register collecting NT+1 coefficient bytes; the first byte shifted in ends up in the top slot.
module coef_shift_reg
  import coef_pkg::*;
(
  input  logic                   CLK,
  input  logic                   clr,
  input  logic                   shift_en,
  input  logic [NB-1:0]          din,
  output logic [(NT+1)*NB-1:0]   dout
);

  always_ff @(posedge CLK) begin
    if (clr) begin
      dout <= '0;
    end else if (shift_en) begin
      dout <= {dout[NT*NB-1:0], din};
    end
  end

endmodule

// File: rtl/coef_loader.sv
// Byte-serial coefficient loader: assembles NT+1 coefficients, verifies a mod-2^NB checksum
// and commits the whole set to B in a single cycle.
//
// Stream contract: CIN is consumed on every rising CLK edge where CVIN=1 and CSTART=0 while a
// load is in progress; there is no back-pressure, and CSTART always wins over a same-cycle byte.
module coef_loader
  import coef_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CSTART,
  input  logic [NB-1:0]         CIN,
  input  logic                  CVIN,
  output logic [(NT+1)*NB-1:0]  B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output coef_state_e           dbg_state
);

  coef_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NB-1:0]         sum_q, sum_d;
  logic                  clr, shift_en, commit, mismatch;
  logic [(NT+1)*NB-1:0]  shadow;

  coef_shift_reg u_shift (
    .CLK      (CLK),
    .clr      (clr | RST),
    .shift_en (shift_en),
    .din      (CIN),
    .dout     (shadow)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    clr      = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    mismatch = 1'b0;
    if (CSTART) begin
      state_d = S_LOAD;
      cnt_d   = '0;
      sum_d   = '0;
      clr     = 1'b1;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (CVIN) begin
            shift_en = 1'b1;
            sum_d    = sum_q + CIN;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(NT)) state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (CVIN) begin
            commit   = (CIN == sum_q);
            mismatch = (CIN != sum_q);
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      B       <= '0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      DONE    <= commit;
      ERR     <= mismatch;
      if (commit) B <= shadow;
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_coef_loader.sv
// Self-checking bench for coef_loader: a byte-queue reference model plus directed and random loads.
module tb_coef_loader;
  import coef_pkg::*;

  localparam int BW = (NT + 1) * NB;
  localparam logic [BW-1:0] NOM_B = 88'hFFFEFC0823322308FCFEFF;

  // clock / reset / DUT
  logic clk = 1'b0;
  logic rst = 1'b0, cstart = 1'b0, cvin = 1'b0;
  logic [NB-1:0] cin = '0;
  logic [BW-1:0] b;
  logic busy, done, err;
  coef_state_e dbg_state;

  always #5 clk = ~clk;

  coef_loader dut (
    .CLK(clk), .RST(rst), .CSTART(cstart), .CIN(cin), .CVIN(cvin),
    .B(b), .BUSY(busy), .DONE(done), .ERR(err), .dbg_state(dbg_state)
  );

  // reference model: a load is just a list of bytes seen since the last start
  bit            m_active;
  logic [NB-1:0] m_q[$];
  logic [BW-1:0] m_b;
  bit            m_done, m_err;
  logic [BW-1:0] exp_q[$];

  int  n_tests = 0, n_fail = 0;
  int  obs_done_n = 0, obs_err_n = 0, m_done_n = 0;
  int  busy_low_n = 0;
  bit  checking = 0, busy_watch = 0;
  logic [NB-1:0] nom [NT+1];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] sum_of(input logic [NB-1:0] v [NT+1]);
    int s = 0;
    for (int i = 0; i <= NT; i++) s += int'(v[i]);
    return NB'(s % (1 << NB));
  endfunction

  task automatic model_step();
    m_done = 0;
    m_err  = 0;
    if (rst) begin
      m_active = 0;
      m_q.delete();
      m_b = '0;
    end else if (cstart) begin
      m_active = 1;
      m_q.delete();
    end else if (m_active && cvin) begin
      if (m_q.size() < NT + 1) begin
        m_q.push_back(cin);
      end else begin
        int s = 0;
        foreach (m_q[i]) s += int'(m_q[i]);
        if (cin == NB'(s % (1 << NB))) begin
          for (int i = 0; i <= NT; i++) m_b[BW-1-i*NB -: NB] = m_q[i];
          m_done = 1;
          m_done_n++;
          exp_q.push_back(m_b);
        end else begin
          m_err = 1;
        end
        m_active = 0;
      end
    end
  endtask

  task automatic compare();
    if (!checking) return;
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("b", b, m_b);
    if (done) begin
      obs_done_n++;
      if (exp_q.size() == 0) chk("commit_unexpected", 1, 0);
      else chk("commit_b", b, exp_q.pop_front());
    end
    if (err) obs_err_n++;
    if (busy_watch && !busy) busy_low_n++;
  endtask

  // driver: at each falling edge the model absorbs the inputs the DUT just sampled,
  // outputs are compared, then the next inputs are applied
  task automatic drive(input bit r, input bit cs, input bit cv, input logic [NB-1:0] d);
    @(negedge clk);
    model_step();
    compare();
    rst = r; cstart = cs; cvin = cv; cin = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, NB'($urandom));
  endtask

  task automatic gaps(input int mg);
    int n = $urandom_range(mg, 0);
    for (int i = 0; i < n; i++) drive(0, 0, 0, NB'($urandom));
  endtask

  task automatic load(input logic [NB-1:0] v [NT+1], input logic [NB-1:0] ck,
                      input int max_gap, input bit start_cv);
    drive(0, 1, start_cv, NB'($urandom));
    for (int i = 0; i <= NT; i++) begin
      gaps(max_gap);
      drive(0, 0, 1, v[i]);
    end
    gaps(max_gap);
    drive(0, 0, 1, ck);
  endtask

  task automatic rand_set(output logic [NB-1:0] v [NT+1]);
    for (int i = 0; i <= NT; i++) v[i] = NB'($urandom);
  endtask

  initial begin
    logic [NB-1:0] rv [NT+1];
    logic [NB-1:0] ck;
    int d0, e0;
    nom = '{8'hFF, 8'hFE, 8'hFC, 8'h08, 8'h23, 8'h32, 8'h23, 8'h08, 8'hFC, 8'hFE, 8'hFF};

    drive(1, 0, 0, 0);
    checking = 1;
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("rst_b", b, '0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("nom_sum_lit", sum_of(nom), 8'h7A);

    // nominal load
    load(nom, 8'h7A, 0, 0);
    idle(2);
    chk("nom_done_n", obs_done_n, 1);
    chk("nom_b_top", b[87:80], 8'hFF);
    chk("nom_b_55", b[55:48], 8'h23);
    chk("nom_b_47", b[47:40], 8'h32);
    chk("nom_b_low", b[7:0], 8'hFF);
    chk("nom_model", m_b, NOM_B);

    // bad checksum
    load(nom, 8'h7B, 0, 0);
    idle(2);
    chk("bad_err_n", obs_err_n, 1);
    chk("bad_done_n", obs_done_n, 1);
    chk("bad_b_kept", b, NOM_B);

    // bubbles, starting from a different committed set
    rand_set(rv);
    load(rv, sum_of(rv), 0, 0);
    idle(1);
    busy_watch = 1;
    load(nom, 8'h7A, 5, 0);
    busy_watch = 0;
    idle(2);
    chk("bub_b", b, NOM_B);
    chk("bub_busy_low_only_at_start", busy_low_n, 1);
    chk("bub_done_n", obs_done_n, 3);

    // restart with a same-cycle byte that must be dropped
    rand_set(rv);
    load(rv, sum_of(rv), 0, 0);
    idle(1);
    d0 = obs_done_n;
    drive(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, NB'($urandom));
    load(nom, 8'h7A, 0, 1);
    idle(2);
    chk("rs_b", b, NOM_B);
    chk("rs_one_done", obs_done_n - d0, 1);

    // reset in the middle of a load
    d0 = obs_done_n;
    e0 = obs_err_n;
    drive(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, nom[i]);
    drive(1, 0, 0, 0);
    idle(3);
    chk("rml_b", b, '0);
    chk("rml_busy", busy, 0);
    chk("rml_no_done", obs_done_n - d0, 0);
    chk("rml_no_err", obs_err_n - e0, 0);
    load(nom, 8'h7A, 0, 0);
    idle(2);
    chk("rml_reload_b", b, NOM_B);
    chk("rml_reload_done", obs_done_n - d0, 1);

    // noise while idle
    d0 = obs_done_n;
    e0 = obs_err_n;
    for (int i = 0; i < 12; i++) drive(0, 0, 1'($urandom), NB'($urandom));
    idle(1);
    chk("noise_b", b, NOM_B);
    chk("noise_busy", busy, 0);
    chk("noise_events", (obs_done_n - d0) + (obs_err_n - e0), 0);

    // random loads: good/bad checksums, bubbles, restarts, back-to-back starts
    for (int it = 0; it < 40; it++) begin
      rand_set(rv);
      ck = sum_of(rv);
      if ($urandom_range(3, 0) == 0) ck = ck ^ NB'($urandom_range(255, 1));
      if ($urandom_range(4, 0) == 0) begin
        drive(0, 1, 0, 0);
        for (int k = $urandom_range(NT, 0); k > 0; k--) drive(0, 0, 1, NB'($urandom));
        load(rv, ck, $urandom_range(2, 0), 1);
      end else begin
        load(rv, ck, $urandom_range(2, 0), 0);
      end
      idle($urandom_range(1, 0));
    end

    idle(3);
    chk("final_exp_q_empty", exp_q.size(), 0);
    chk("final_done_count", obs_done_n, m_done_n);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
